// File: rtl/sonar_pkg.sv
// Shared types and default timing for the sonar trigger/echo link.
package sonar_pkg;

  localparam int unsigned ECHO_W_DEF    = 18;
  localparam int unsigned TRIG_MIN_DEF  = 10;
  localparam int unsigned BURST_DLY_DEF = 200;
  localparam int unsigned ECHO_MAX_DEF  = 38000;
  localparam int unsigned HOLDOFF_DEF   = 1000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    BURST = 3'd2,
    ECHO  = 3'd3,
    HOLD  = 3'd4
  } sonar_state_e;

endpackage

// File: rtl/sonar_dcnt.sv
// Loadable down-counter with enable and zero flag; stops at zero.
module sonar_dcnt #(
  parameter int unsigned W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/sonar_echo_responder.sv
// Sensor-side model of an ultrasonic ranger: answers a valid trig with an echo of programmed width.
// Optional macro SONAR_TRIG_SYNC_EN adds a 2-flop synchronizer on trig.
module sonar_echo_responder
  import sonar_pkg::*;
#(
  parameter int unsigned TRIG_MIN  = TRIG_MIN_DEF,
  parameter int unsigned BURST_DLY = BURST_DLY_DEF,
  parameter int unsigned ECHO_MAX  = ECHO_MAX_DEF,
  parameter int unsigned HOLDOFF   = HOLDOFF_DEF,
  parameter int unsigned ECHO_W    = ECHO_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [ECHO_W-1:0] dist_us,
  input  logic              obj_present,
  output logic              echo,
  output logic              busy,
  output logic              trig_err
);

  localparam logic [ECHO_W-1:0] TRIG_MIN_V  = ECHO_W'(TRIG_MIN);
  localparam logic [ECHO_W-1:0] ECHO_MAX_V  = ECHO_W'(ECHO_MAX);
  // Counter reloads are N-1 so the state lasts exactly N cycles.
  localparam logic [ECHO_W-1:0] BURST_LD_V  = ECHO_W'(BURST_DLY - 1);
  localparam logic [ECHO_W-1:0] HOLD_LD_V   = ECHO_W'(HOLDOFF - 1);

  sonar_state_e      state, next_state;
  logic              trig_s, trig_q, trig_rise_c;
  logic [ECHO_W-1:0] hcnt, hcnt_d;
  logic [ECHO_W-1:0] width_q, width_d, width_c;
  logic              cnt_load, cnt_en, cnt_zero;
  logic [ECHO_W-1:0] cnt_val;
  logic              echo_d, busy_d, trig_err_d;

`ifdef SONAR_TRIG_SYNC_EN
  logic [1:0] trig_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_sync <= 2'b00;
    end else begin
      trig_sync <= {trig_sync[0], trig};
    end
  end

  assign trig_s = trig_sync[1];
`else
  assign trig_s = trig;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig_s;
    end
  end

  assign trig_rise_c = trig_s & ~trig_q;

  // Echo width clamp applied at the moment the trigger is accepted.
  always_comb begin
    width_c = dist_us;
    if (!obj_present) begin
      width_c = ECHO_MAX_V;
    end else if (dist_us == '0) begin
      width_c = ECHO_W'(1);
    end else if (dist_us > ECHO_MAX_V) begin
      width_c = ECHO_MAX_V;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (trig_rise_c) next_state = ARM;
      ARM:     if (!trig_s) next_state = (hcnt >= TRIG_MIN_V) ? BURST : IDLE;
      BURST:   if (cnt_zero) next_state = ECHO;
      ECHO:    if (cnt_zero) next_state = HOLD;
      HOLD:    if (cnt_zero) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_en     = 1'b0;
    hcnt_d     = hcnt;
    width_d    = width_q;
    echo_d     = (next_state == ECHO);
    busy_d     = (next_state != IDLE);
    trig_err_d = 1'b0;
    case (state)
      IDLE: begin
        if (trig_rise_c) hcnt_d = ECHO_W'(1);
      end
      ARM: begin
        if (trig_s) begin
          if (hcnt < TRIG_MIN_V) hcnt_d = hcnt + ECHO_W'(1);
        end else if (next_state == BURST) begin
          width_d  = width_c;
          cnt_load = 1'b1;
          cnt_val  = BURST_LD_V;
        end else begin
          trig_err_d = 1'b1;
        end
      end
      BURST: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = width_q - ECHO_W'(1);
        end
      end
      ECHO: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = HOLD_LD_V;
        end
      end
      HOLD: begin
        cnt_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo     <= 1'b0;
      busy     <= 1'b0;
      trig_err <= 1'b0;
      hcnt     <= '0;
      width_q  <= '0;
    end else begin
      echo     <= echo_d;
      busy     <= busy_d;
      trig_err <= trig_err_d;
      hcnt     <= hcnt_d;
      width_q  <= width_d;
    end
  end

  sonar_dcnt #(.W(ECHO_W)) u_dcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .zero_c   (cnt_zero)
  );

endmodule

// File: tb/tb_sonar_echo_responder.sv
// Directed bench for sonar_echo_responder with an expected-transaction queue.
// Build with or without SONAR_TRIG_SYNC_EN; trig-referenced timing shifts by LAT.
module tb_sonar_echo_responder;

  localparam int T_MIN = 10;
  localparam int B     = 200;
  localparam int EMAX  = 3800;
  localparam int H     = 1000;
`ifdef SONAR_TRIG_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int busy_rise;
    int rise;
    int fall;
    int busy_fall;
    int err_at;
    int err_n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic [17:0] dist_us = '0;
  logic        obj_present = 1'b1;
  logic        echo, busy, trig_err;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_k = 0;
  exp_t sb[$];

  sonar_echo_responder #(
    .TRIG_MIN  (T_MIN),
    .BURST_DLY (B),
    .ECHO_MAX  (EMAX),
    .HOLDOFF   (H),
    .ECHO_W    (18)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trig        (trig),
    .dist_us     (dist_us),
    .obj_present (obj_present),
    .echo        (echo),
    .busy        (busy),
    .trig_err    (trig_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Monitor: measure each busy episode and compare against the queue head.
  logic p_echo = 1'b0, p_busy = 1'b0, p_err = 1'b0;
  int   m_br = -1, m_r = -1, m_f = -1, m_err = -1, m_errn = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      p_echo = 1'b0; p_busy = 1'b0; p_err = 1'b0;
      m_br = -1; m_r = -1; m_f = -1; m_err = -1; m_errn = 0;
    end else begin
      if (busy && !p_busy) begin
        m_br = cyc; m_r = -1; m_f = -1; m_err = -1; m_errn = 0;
      end
      if (echo && !p_echo) m_r = cyc;
      if (!echo && p_echo) m_f = cyc;
      if (trig_err) begin
        check("trig_err_single", int'(p_err), 0);
        if (m_err < 0) m_err = cyc;
        m_errn++;
      end
      if (!busy && p_busy) begin
        if (sb.size() == 0) begin
          check("unexpected_episode", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("busy_rise", m_br, e.busy_rise);
          check("echo_rise", m_r, e.rise);
          check("echo_fall", m_f, e.fall);
          check("busy_fall", cyc, e.busy_fall);
          check("trig_err_at", m_err, e.err_at);
          check("trig_err_n", m_errn, e.err_n);
        end
      end
      p_echo = echo; p_busy = busy; p_err = trig_err;
    end
  end

  // Drive a trig pulse of n samples; w < 0 means the trigger must be rejected.
  task automatic send_trig(input int n, input int w);
    exp_t e;
    int   br, k;
    @(negedge clk);
    trig = 1'b1;
    br = cyc + 1 + LAT;
    repeat (n) @(negedge clk);
    trig = 1'b0;
    k = cyc + 1 + LAT;
    last_k = k;
    e.busy_rise = br;
    if (w < 0) begin
      e.rise = -1; e.fall = -1; e.busy_fall = k; e.err_at = k; e.err_n = 1;
    end else begin
      e.rise = k + B; e.fall = k + B + w; e.busy_fall = k + B + w + H;
      e.err_at = -1; e.err_n = 0;
    end
    sb.push_back(e);
  endtask

  task automatic pulse(input int n);
    trig = 1'b1;
    repeat (n) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_cycle(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((busy || sb.size() != 0) && n < budget);
    check("idle_within_budget", int'(n < budget), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_echo", int'(echo), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_trig_err", int'(trig_err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal 580-cycle echo.
    dist_us = 18'd580; obj_present = 1'b1;
    send_trig(T_MIN, 580);
    wait_idle(10000);

    // Short trigger is rejected, then a minimum-length one is accepted.
    send_trig(T_MIN - 1, -1);
    wait_idle(100);
    check("no_echo_after_reject", int'(echo), 0);
    send_trig(T_MIN, 580);
    wait_idle(10000);

    // Width clamping and boundary values.
    obj_present = 1'b0; dist_us = 18'd580;
    send_trig(T_MIN, EMAX);
    wait_idle(10000);
    obj_present = 1'b1; dist_us = 18'd50000;
    send_trig(T_MIN, EMAX);
    wait_idle(10000);
    dist_us = 18'd0;
    send_trig(T_MIN, 1);
    wait_idle(10000);
    dist_us = 18'(EMAX);
    send_trig(T_MIN, EMAX);
    wait_idle(10000);

    // Retrigger pulses in BURST, ECHO and HOLD are ignored.
    dist_us = 18'd300;
    send_trig(T_MIN + 2, 300);
    wait_cycle(last_k + 50);
    pulse(12);
    wait_cycle(last_k + B + 100);
    pulse(12);
    wait_cycle(last_k + B + 300 + 200);
    pulse(12);
    wait_idle(10000);

    // trig held high across HOLD->IDLE must not start a new cycle.
    dist_us = 18'd20;
    send_trig(T_MIN, 20);
    wait_cycle(last_k + B + 20 + H - 10);
    trig = 1'b1;
    wait_idle(10000);
    repeat (30) @(negedge clk);
    check("held_trig_no_cycle", int'(busy), 0);
    trig = 1'b0;
    repeat (5) @(negedge clk);
    check("held_trig_release_idle", int'(busy), 0);

    // Inputs changed mid-BURST have no effect on the latched width.
    dist_us = 18'd580;
    send_trig(T_MIN, 580);
    wait_cycle(last_k + 50);
    dist_us = 18'd100; obj_present = 1'b0;
    wait_idle(10000);
    obj_present = 1'b1; dist_us = 18'd580;

    // Asynchronous reset mid-ECHO, then recovery.
    send_trig(T_MIN, 580);
    wait_cycle(last_k + B + 100);
    check("echo_high_before_rst", int'(echo), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_echo", int'(echo), 0);
    check("async_rst_busy", int'(busy), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("post_rst_busy", int'(busy), 0);
    send_trig(T_MIN, 580);
    wait_idle(10000);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
